// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - successive-approximation search controller driving an external comparator
// Optional probe counter output enabled by defining SAR_SEARCH_PROBE_CNT_EN.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] cmp_a,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
`ifdef SAR_SEARCH_PROBE_CNT_EN
    ,
    output logic [$clog2(WIDTH+2)-1:0] probe_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cmp_a_n, result_n;
    logic [WIDTH:0]   lo, hi, lo_n, hi_n;
    logic             found_n, err_n;
    logic             one_hot;

    assign busy    = (state == PROBE);
    assign done    = (state == DONE);
    assign one_hot = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                     ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                     ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

    always_comb begin
        state_n  = state;
        cmp_a_n  = cmp_a;
        lo_n     = lo;
        hi_n     = hi;
        result_n = result;
        found_n  = found;
        err_n    = err;
        case (state)
            IDLE: begin
                if (start) begin
                    lo_n     = '0;
                    hi_n     = {1'b0, {WIDTH{1'b1}}};
                    cmp_a_n  = {1'b0, {(WIDTH-1){1'b1}}};
                    found_n  = 1'b0;
                    err_n    = 1'b0;
                    result_n = '0;
                    state_n  = PROBE;
                end
            end
            PROBE: begin
                if (!one_hot) begin
                    err_n    = 1'b1;
                    found_n  = 1'b0;
                    result_n = cmp_a;
                    state_n  = DONE;
                end else if (cmp_eq) begin
                    found_n  = 1'b1;
                    result_n = cmp_a;
                    state_n  = DONE;
                end else begin
                    if (cmp_gt)
                        hi_n = {1'b0, cmp_a} - (WIDTH+1)'(1);
                    else
                        lo_n = {1'b0, cmp_a} + (WIDTH+1)'(1);
                    // lo never goes negative, hi may reach -1: extend each accordingly
                    if ($signed({1'b0, lo_n}) > $signed({hi_n[WIDTH], hi_n})) begin
                        found_n  = 1'b0;
                        result_n = cmp_a;
                        state_n  = DONE;
                    end else begin
                        cmp_a_n = WIDTH'((lo_n + hi_n) >> 1);
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cmp_a  <= '0;
            lo     <= '0;
            hi     <= '0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cmp_a  <= cmp_a_n;
            lo     <= lo_n;
            hi     <= hi_n;
            result <= result_n;
            found  <= found_n;
            err    <= err_n;
        end
    end

`ifdef SAR_SEARCH_PROBE_CNT_EN
    localparam int PCW = $clog2(WIDTH+2);

    always_ff @(posedge clk) begin
        if (rst)
            probe_cnt <= '0;
        else if (state == IDLE && start)
            probe_cnt <= '0;
        else if (state == PROBE)
            probe_cnt <= probe_cnt + PCW'(1);
    end
`endif

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb/tb_sar_search_ctrl.sv - self-checking bench for sar_search_ctrl with a behavioural comparator
module tb_sar_search_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cmp_a;
    logic       cmp_gt, cmp_lt, cmp_eq;
    logic       busy, done, found, err;
    logic [3:0] result;
`ifdef SAR_SEARCH_PROBE_CNT_EN
    logic [2:0] probe_cnt;
`endif

    // 0 ideal, 1 lt stuck, 2 forced flags, 3 gt stuck
    int         mode = 0;
    logic [3:0] b_val = '0;
    logic [2:0] force_flags = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    always_comb begin
        cmp_gt = 1'b0;
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        case (mode)
            0: begin
                cmp_gt = cmp_a > b_val;
                cmp_lt = cmp_a < b_val;
                cmp_eq = cmp_a == b_val;
            end
            1: cmp_lt = 1'b1;
            2: {cmp_gt, cmp_lt, cmp_eq} = force_flags;
            default: cmp_gt = 1'b1;
        endcase
    end

    sar_search_ctrl #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_a  (cmp_a),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .err    (err),
        .result (result)
`ifdef SAR_SEARCH_PROBE_CNT_EN
        ,
        .probe_cnt (probe_cnt)
`endif
    );

    task automatic run_search(input string name, input logic [3:0] b, input int m,
                              input logic [2:0] ff, input logic ef, input logic ee,
                              input logic [3:0] er, input int lat, input int poke);
        int         n_probe;
        bit         seen;
        logic [3:0] exp_a;
        n_probe = exp_q.size();
        seen = 1'b0;
        b_val = b;
        mode = m;
        force_flags = ff;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            start = (cyc == poke);
            if (done) begin
                seen = 1'b1;
                n_checks++;
                if (cyc !== lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, cyc, lat); end
                n_checks++;
                if (found !== ef) begin n_fail++; $display("FAIL %s found: got %b want %b", name, found, ef); end
                n_checks++;
                if (err !== ee) begin n_fail++; $display("FAIL %s err: got %b want %b", name, err, ee); end
                n_checks++;
                if (result !== er) begin n_fail++; $display("FAIL %s result: got %0d want %0d", name, result, er); end
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_in_done: got %b want 0", name, busy); end
`ifdef SAR_SEARCH_PROBE_CNT_EN
                n_checks++;
                if (probe_cnt !== 3'(n_probe)) begin n_fail++; $display("FAIL %s probe_cnt: got %0d want %0d", name, probe_cnt, n_probe); end
`endif
                break;
            end
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy cycle %0d: got %b want 1", name, cyc, busy); end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s extra_probe: got cmp_a=%0d want no probe", name, cmp_a);
            end else begin
                exp_a = exp_q.pop_front();
                if (cmp_a !== exp_a) begin n_fail++; $display("FAIL %s cmp_a probe %0d: got %0d want %0d", name, cyc, cmp_a, exp_a); end
            end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL %s timeout: got no done want done at %0d", name, lat); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s missing_probes: got %0d left want 0", name, exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
        end
        n_checks++;
        if (result !== er) begin n_fail++; $display("FAIL %s result_hold: got %0d want %0d", name, result, er); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmp_a, result, busy, done, found, err} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset: got cmp_a=%0d result=%0d busy=%b done=%b found=%b err=%b want all 0",
                     cmp_a, result, busy, done, found, err);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy: got %b want 0", busy); end
    endtask

    task automatic test_ideal();
        exp_q = '{4'd7, 4'd11, 4'd13, 4'd12};
        run_search("b12", 4'd12, 0, 3'b000, 1'b1, 1'b0, 4'd12, 5, 0);
        exp_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        run_search("b15", 4'd15, 0, 3'b000, 1'b1, 1'b0, 4'd15, 6, 0);
        exp_q = '{4'd7, 4'd3, 4'd1, 4'd0};
        run_search("b0", 4'd0, 0, 3'b000, 1'b1, 1'b0, 4'd0, 5, 0);
        exp_q = '{4'd7, 4'd3, 4'd5};
        run_search("b5", 4'd5, 0, 3'b000, 1'b1, 1'b0, 4'd5, 4, 0);
    endtask

    task automatic test_stuck();
        exp_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        run_search("lt_stuck", 4'd0, 1, 3'b000, 1'b0, 1'b0, 4'd15, 6, 0);
        exp_q = '{4'd7, 4'd3, 4'd1, 4'd0};
        run_search("gt_stuck", 4'd0, 3, 3'b000, 1'b0, 1'b0, 4'd0, 5, 0);
    endtask

    task automatic test_error();
        exp_q = '{4'd7};
        run_search("flags_000", 4'd0, 2, 3'b000, 1'b0, 1'b1, 4'd7, 2, 0);
        exp_q = '{4'd7};
        run_search("flags_110", 4'd0, 2, 3'b110, 1'b0, 1'b1, 4'd7, 2, 0);
    endtask

    task automatic test_start_ignored();
        exp_q = '{4'd7, 4'd11, 4'd13, 4'd12};
        run_search("start_busy", 4'd12, 0, 3'b000, 1'b1, 1'b0, 4'd12, 5, 2);
        exp_q = '{4'd7, 4'd3, 4'd5};
        run_search("start_done", 4'd5, 0, 3'b000, 1'b1, 1'b0, 4'd5, 4, 4);
    endtask

    task automatic test_reset_mid_search();
        bit saw_done;
        saw_done = 1'b0;
        b_val = 4'd12;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmp_a, result, busy, done, found, err} !== 12'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got cmp_a=%0d result=%0d busy=%b done=%b found=%b err=%b want all 0",
                     cmp_a, result, busy, done, found, err);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin n_fail++; $display("FAIL rst_mid_quiet: got done/busy activity want none"); end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck();
        test_error();
        test_start_ignored();
        test_reset_mid_search();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Binary-search (successive-approximation) controller that drives operand A of an external combinational magnitude comparator and consumes its GT/LT/EQ flags.
- Finds the unknown value presented on comparator operand B in at most WIDTH+1 probe cycles.
- Sits on the far side of the existing Comparator block, acting as its initiator/consumer.
- Provides a start/busy/done handshake toward a host FSM.

Parameters:
WIDTH, 4, operand width in bits; search range is 0 .. 2^WIDTH-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; accepted only in IDLE
cmp_a  output  WIDTH  current guess, wired to comparator operand A
cmp_gt  input  1  comparator flag, A > B
cmp_lt  input  1  comparator flag, A < B
cmp_eq  input  1  comparator flag, A == B
busy  output  1  high from the cycle after start is accepted through the last PROBE cycle
done  output  1  one-cycle pulse in the DONE state
found  output  1  valid from done onward; 1 means EQ was seen
err  output  1  valid from done onward; 1 means the flags were not one-hot
result  output  WIDTH  guess at termination; held until the next accepted start

Behaviour:
- Reset, synchronous on clk with rst=1:
  - state=IDLE; cmp_a, result = 0; busy, done, found, err = 0.
  - rst mid-search aborts immediately, with no done pulse.
- Internal bounds lo and hi are WIDTH+1 bits wide so that hi=-1 and lo=2^WIDTH are representable.
- guess = (lo+hi)>>1, computed at WIDTH+1 bits and truncated to WIDTH.
- State IDLE:
  - cmp_a holds its last value.
  - On start=1: lo=0, hi=2^WIDTH-1, cmp_a=(2^WIDTH-1)>>1; clear found, err and result; next state PROBE.
- State PROBE, one probe per cycle; busy=1; flags sampled at the clock edge ending the cycle. Priority:
  - Flags not exactly one-hot (none set, or more than one set): err=1, found=0, result=cmp_a; go to DONE.
  - cmp_eq: found=1, result=cmp_a; go to DONE.
  - cmp_gt: hi=cmp_a-1.
  - cmp_lt: lo=cmp_a+1.
  - After a GT/LT update, if new lo > new hi: found=0, result=cmp_a; go to DONE.
  - Otherwise cmp_a = new guess; stay in PROBE.
- State DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: start accepted at edge T; probe k occupies cycle T+k; DONE is the cycle after the final probe.
  - Worst case is WIDTH+1 probes, so done appears at cycle T+WIDTH+2.
- start while busy or in DONE: ignored, never queued.
- start and rst together: rst wins.
- The comparator is combinational, so the flags must settle within the same cycle cmp_a changes. No wait states.

Optional Feature:
- Macro SAR_SEARCH_PROBE_CNT_EN.
- When defined:
  - Adds output probe_cnt, width $clog2(WIDTH+2).
  - Cleared on accepted start; incremented once per PROBE cycle, including the terminating probe.
  - Held after done; reset value 0.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, ideal comparator, B=12, start pulse:
  - cmp_a sequence 7, 11, 13, 12.
  - done 5 cycles after start, found=1, result=12, err=0; probe_cnt=4 if enabled.
- B=15:
  - cmp_a sequence 7, 11, 13, 14, 15.
  - done at T+6, found=1, result=15.
- B=0:
  - cmp_a sequence 7, 3, 1, 0.
  - found=1, result=0; no underflow artefacts.
- Comparator stubbed with cmp_lt stuck at 1:
  - cmp_a sequence 7, 11, 13, 14, 15, then lo=16 > hi=15.
  - done with found=0, err=0, result=15.
- Error path:
  - Flags forced to 000 on the first probe: done at T+2 with err=1, found=0, result=7.
  - Repeat with 110: same response.
- Control:
  - rst asserted during the 2nd probe: next cycle all outputs are 0 and state is IDLE; no done pulse.
  - start pulsed while busy: no effect on the sequence or on result.
